// File: rtl/fpu_dispatch.sv
// fpu_dispatch: issues one FP op to a one-hot selected unit, then returns its result on a registered output.
// Latency: minimum 3 cycles from op accept to o_res_valid. Throughput is at best one op per 4 cycles.
// Backpressure: o_op_ready is high only in IDLE. The unit handshake and o_res_valid are held until their ready arrives.
//
// Ports:
//   i_clk, i_rstn                      clock (rising edge), asynchronous active-low reset
//   i_op_valid / o_op_ready / i_op_sel op request; i_op_sel is one-hot and is sampled on accept
//   o_unit_in_valid / i_unit_in_ready  per-unit issue handshake
//   i_unit_out_valid / i_unit_out      per-unit result; unit k occupies [k*DATA_W +: DATA_W]
//   o_res / o_res_valid / i_res_ready  captured result and its handshake
//   o_busy                             high in every state except IDLE
//   o_err_sel                          1-cycle pulse when an op is dropped because i_op_sel is not one-hot
//   o_err_timeout                      1-cycle pulse when the watchdog expires
//
// Optional feature: define FPU_DISPATCH_TIMEOUT_EN to enable the ISSUE/WAIT watchdog.
// Without it, o_err_timeout is constant 0.
module fpu_dispatch #(
   parameter int N_UNITS   = 10,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT_W = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rstn,
   input  logic                        i_op_valid,
   output logic                        o_op_ready,
   input  logic [N_UNITS-1:0]          i_op_sel,
   output logic [N_UNITS-1:0]          o_unit_in_valid,
   input  logic [N_UNITS-1:0]          i_unit_in_ready,
   input  logic [N_UNITS-1:0]          i_unit_out_valid,
   input  logic [N_UNITS*DATA_W-1:0]   i_unit_out,
   output logic [DATA_W-1:0]           o_res,
   output logic                        o_res_valid,
   input  logic                        i_res_ready,
   output logic                        o_busy,
   output logic                        o_err_sel,
   output logic                        o_err_timeout
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [N_UNITS-1:0]   r_sel;
   logic [DATA_W-1:0]    r_res;
   logic                 r_err_sel;

   logic                 w_sel_onehot;
   logic                 w_accept;
   logic                 w_bad_sel;
   logic                 w_capture;
   logic                 w_timeout;
   logic                 w_in_hs;
   logic                 w_out_vld;
   logic [DATA_W-1:0]    w_mux_res;

   // One-hot test: non-zero, and clearing the lowest set bit leaves nothing.
   assign w_sel_onehot = (i_op_sel != '0) && ((i_op_sel & (i_op_sel - 1'b1)) == '0);

   // Only the latched unit's handshake bits matter; all other units are masked off.
   assign w_in_hs   = |(r_sel & i_unit_in_ready);
   assign w_out_vld = |(r_sel & i_unit_out_valid);

   // AND-OR result mux. r_sel is one-hot, so no priority is implied.
   always_comb begin
      w_mux_res = '0;
      for (int k = 0; k < N_UNITS; k++) begin
         w_mux_res = w_mux_res | ({DATA_W{r_sel[k]}} & i_unit_out[k*DATA_W +: DATA_W]);
      end
   end

`ifdef FPU_DISPATCH_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] C_CNT_LAST = {TIMEOUT_W{1'b1}} - 1'b1;

   logic [TIMEOUT_W-1:0] r_cnt;

   // In the Nth ISSUE/WAIT cycle the counter holds N-1.
   // Expiry therefore lands in cycle 2**TIMEOUT_W-1.
   // The FSM leaves the state at that point, so the counter never wraps.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= '0;
      end else if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign w_timeout = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && (r_cnt == C_CNT_LAST);
`else
   // No watchdog in this build. The width parameter is referenced only to keep it in use.
   assign w_timeout = 1'b0 & (TIMEOUT_W > 0);
`endif

   // Next-state and output decode.
   // Every output depends on registered state only.
   always_comb begin
      w_state_nxt     = r_state;
      w_accept        = 1'b0;
      w_bad_sel       = 1'b0;
      w_capture       = 1'b0;
      o_op_ready      = 1'b0;
      o_unit_in_valid = '0;
      o_res_valid     = 1'b0;
      o_busy          = 1'b1;
      o_err_timeout   = w_timeout;
      case (r_state)
         S_IDLE: begin
            o_op_ready = 1'b1;
            o_busy     = 1'b0;
            if (i_op_valid) begin
               if (w_sel_onehot) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_ISSUE;
               end else begin
                  w_bad_sel   = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            o_unit_in_valid = r_sel;
            if (w_timeout) begin
               w_state_nxt = S_DONE;
            end else if (w_in_hs) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            // The watchdog wins over a result arriving in the same cycle.
            // Once it fires, that unit's result is abandoned.
            if (w_timeout) begin
               w_state_nxt = S_DONE;
            end else if (w_out_vld) begin
               w_capture   = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            o_res_valid = 1'b1;
            if (i_res_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state   <= S_IDLE;
         r_sel     <= '0;
         r_res     <= '0;
         r_err_sel <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_err_sel <= w_bad_sel;
         if (w_accept) begin
            r_sel <= i_op_sel;
         end
         if (w_timeout) begin
            r_res <= '0;
         end else if (w_capture) begin
            r_res <= w_mux_res;
         end
      end
   end

   assign o_res     = r_res;
   assign o_err_sel = r_err_sel;

endmodule

// File: tb/tb_fpu_dispatch.sv
// tb_fpu_dispatch: directed vectors for fpu_dispatch, checked through a result scoreboard.
// Latency: expected results are queued at issue and popped on each o_res_valid & i_res_ready handshake.
// Backpressure: the bench drives unit ready, unit valid and i_res_ready directly, cycle by cycle.
module tb_fpu_dispatch;
   localparam int N  = 10;
   localparam int W  = 32;
   localparam int TW = 4;

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic           op_valid = 1'b0;
   logic           op_ready;
   logic [N-1:0]   op_sel = '0;
   logic [N-1:0]   unit_in_valid;
   logic [N-1:0]   unit_in_ready = '0;
   logic [N-1:0]   unit_out_valid = '0;
   logic [N*W-1:0] unit_out = '0;
   logic [W-1:0]   res;
   logic           res_valid;
   logic           res_ready = 1'b0;
   logic           busy;
   logic           err_sel;
   logic           err_timeout;

   int             checks = 0;
   int             errors = 0;
   int             err_sel_pulses = 0;
   logic [W-1:0]   exp_q[$];

   fpu_dispatch #(.N_UNITS(N), .DATA_W(W), .TIMEOUT_W(TW)) dut (
      .i_clk            (clk),
      .i_rstn           (rstn),
      .i_op_valid       (op_valid),
      .o_op_ready       (op_ready),
      .i_op_sel         (op_sel),
      .o_unit_in_valid  (unit_in_valid),
      .i_unit_in_ready  (unit_in_ready),
      .i_unit_out_valid (unit_out_valid),
      .i_unit_out       (unit_out),
      .o_res            (res),
      .o_res_valid      (res_valid),
      .i_res_ready      (res_ready),
      .o_busy           (busy),
      .o_err_sel        (err_sel),
      .o_err_timeout    (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_out(input int k, input logic [W-1:0] v);
      unit_out[k*W +: W] = v;
   endtask

   // Monitor: pops the scoreboard on every result handshake and counts err_sel pulses.
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (rstn && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got 0x%0h, expected no result", res);
         end else begin
            e = exp_q.pop_front();
            chk("result", res, e);
         end
      end
      if (err_sel) err_sel_pulses++;
   end

   initial begin
      int held;
      int stable;
      int cnt_rv;
      int base;
      int seen;
      int bcnt;
      int ecnt;

      // Reset state.
      @(posedge clk);
      #1;
      chk("rst_op_ready", op_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_unit_in_valid", unit_in_valid, 0);
      chk("rst_res", res, 0);
      chk("rst_err", {err_sel, err_timeout}, 0);
      step();
      rstn = 1'b1;
      step();

      // 1. Zero-wait path on unit 2 (fmul).
      unit_in_ready = '1;
      res_ready = 1'b1;
      op_valid = 1'b1;
      op_sel = 10'b0000000100;
      exp_q.push_back(32'h40400000);
      step();                                  // cycle 1: ISSUE
      op_valid = 1'b0;
      op_sel = '0;
      @(negedge clk);
      chk("t1_issue_in_valid", unit_in_valid, 10'b0000000100);
      chk("t1_issue_op_ready", op_ready, 0);
      step();                                  // cycle 2: WAIT
      unit_out_valid = 10'b0000000100;
      set_out(2, 32'h40400000);
      @(negedge clk);
      chk("t1_wait_in_valid", unit_in_valid, 0);
      chk("t1_wait_res_valid", res_valid, 0);
      step();                                  // cycle 3: DONE
      unit_out_valid = '0;
      @(negedge clk);
      chk("t1_res_valid_c3", res_valid, 1);
      step();                                  // cycle 4: IDLE
      @(negedge clk);
      chk("t1_op_ready_c4", op_ready, 1);
      chk("t1_res_valid_c4", res_valid, 0);
      step();

      // 2. Issue backpressure, then result backpressure, on unit 0.
      unit_in_ready = '0;
      res_ready = 1'b0;
      op_valid = 1'b1;
      op_sel = 10'b0000000001;
      step();
      op_valid = 1'b0;
      op_sel = '0;
      held = 0;
      for (int i = 0; i < 6; i++) begin
         unit_in_ready = (i == 5) ? 10'b0000000001 : 10'b0;
         @(negedge clk);
         if (unit_in_valid == 10'b0000000001) held++;
         step();
      end
      chk("t2_in_valid_held_cycles", held, 6);
      @(negedge clk);
      chk("t2_in_valid_dropped", unit_in_valid, 0);
      unit_out_valid = 10'b0000000001;
      set_out(0, 32'h12345678);
      exp_q.push_back(32'h12345678);
      step();
      unit_out_valid = '0;
      stable = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (res_valid && res == 32'h12345678) stable++;
         step();
      end
      chk("t2_done_stable_cycles", stable, 3);
      res_ready = 1'b1;
      step();
      @(negedge clk);
      chk("t2_back_to_idle", op_ready, 1);
      step();

      // 3. Bad selects: zero and multi-hot.
      unit_in_ready = '1;
      base = err_sel_pulses;
      op_valid = 1'b1;
      op_sel = '0;
      step();
      op_valid = 1'b0;
      @(negedge clk);
      chk("t3_err_sel_zero", err_sel, 1);
      chk("t3_zero_no_issue", unit_in_valid, 0);
      chk("t3_zero_idle", busy, 0);
      step();
      @(negedge clk);
      chk("t3_err_sel_one_cycle", err_sel, 0);
      op_valid = 1'b1;
      op_sel = 10'b0000000011;
      step();
      op_valid = 1'b0;
      op_sel = '0;
      @(negedge clk);
      chk("t3_err_sel_multi", err_sel, 1);
      chk("t3_multi_no_issue", unit_in_valid, 0);
      chk("t3_multi_op_ready", op_ready, 1);
      step();
      @(negedge clk);
      step();
      chk("t3_err_sel_pulse_count", err_sel_pulses - base, 2);

      // 4. Cross-talk: unit 3 fires while unit 4 is selected.
      op_valid = 1'b1;
      op_sel = 10'b0000010000;
      exp_q.push_back(32'h3F800000);
      step();                                  // ISSUE
      op_valid = 1'b0;
      op_sel = '0;
      step();                                  // WAIT
      unit_out_valid = 10'b0000001000;
      set_out(3, 32'hDEADBEEF);
      step();                                  // still WAIT
      unit_out_valid = '0;
      @(negedge clk);
      chk("t4_crosstalk_no_result", res_valid, 0);
      chk("t4_crosstalk_still_busy", busy, 1);
      unit_out_valid = 10'b0000010000;
      set_out(3, 32'h0);
      set_out(4, 32'h3F800000);
      step();                                  // DONE
      unit_out_valid = '0;
      @(negedge clk);
      chk("t4_res_valid", res_valid, 1);
      step();

      // 5. Asynchronous reset mid-WAIT, then a stale result from the unit.
      op_valid = 1'b1;
      op_sel = 10'b0000000010;
      step();
      op_valid = 1'b0;
      op_sel = '0;
      step();                                  // WAIT
      #2;
      rstn = 1'b0;
      #1;
      chk("t5_async_busy", busy, 0);
      chk("t5_async_op_ready", op_ready, 1);
      chk("t5_async_res_valid", res_valid, 0);
      step();
      step();
      rstn = 1'b1;
      unit_out_valid = 10'b0000000010;
      set_out(1, 32'hBAD0BAD0);
      step();
      unit_out_valid = '0;
      cnt_rv = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (res_valid) cnt_rv++;
         step();
      end
      chk("t5_no_stale_result", cnt_rv, 0);
      chk("t5_idle_after_stale", busy, 0);
      chk("t5_res_cleared", res, 0);

      // 6. Unit accepts the op but never returns a result.
      unit_in_ready = '1;
      res_ready = 1'b1;
      op_valid = 1'b1;
      op_sel = 10'b0000000001;
      step();                                  // first ISSUE/WAIT cycle
      op_valid = 1'b0;
      op_sel = '0;
`ifdef FPU_DISPATCH_TIMEOUT_EN
      exp_q.push_back(32'h0);
      seen = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (err_timeout && seen == 0) seen = n;
         step();
         if (seen != 0) break;
      end
      chk("t6_timeout_cycle", seen, 15);
      @(negedge clk);
      chk("t6_timeout_res_valid", res_valid, 1);
      chk("t6_timeout_pulse_ends", err_timeout, 0);
      step();
      step();
`else
      bcnt = 0;
      ecnt = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (err_timeout) ecnt++;
         step();
      end
      chk("t6_busy_100_cycles", bcnt, 100);
      chk("t6_no_err_timeout", ecnt, 0);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      step();
      @(negedge clk);
      chk("t6_recover_op_ready", op_ready, 1);
      step();
`endif

      step();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
